// File: rtl/debug_mem_dump_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the debug memory dumper: FSM encoding and byte-count sizing.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package debug_mem_dump_pkg;

  // FSM state encoding, kept as plain 2-bit constants for legacy tools.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Sizing at the default 32-bit word width.
  localparam int NBITS_DEFAULT = 32;
  localparam int NBYTES        = NBITS_DEFAULT / 8;
  localparam int BCNT_W        = $clog2(NBYTES);

  // Bytes per word for an arbitrary word width.
  function automatic int nbytes_of(input int nbits);
    return nbits / 8;
  endfunction

  // byte_cnt width; a one-byte word still needs a 1-bit counter.
  function automatic int bcnt_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/debug_mem_dump_word_serializer.sv
`timescale 1ns/1ps
// Holds one memory word and shifts it out MSB byte first over a valid/ready byte port.
// Latency: byte 0 valid the cycle after i_load; one byte per accepted handshake.
// Backpressure: valid/data held stable until i_tx_ready; last-byte pulse only on the final accept.
//
// Ports:
//   i_clk, i_reset       clock, async active-low reset
//   i_load, i_word       capture a new word (only issued while idle)
//   o_tx_data/o_tx_valid byte stream to the UART TX, i_tx_ready accepts
//   o_last_acc           combinational pulse: last byte of the word accepted this cycle
module debug_mem_dump_word_serializer
  import debug_mem_dump_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [NBITS-1:0] i_word,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_valid,
  input  logic             i_tx_ready,
  output logic             o_last_acc
);

  localparam int NB = nbytes_of(NBITS);
  localparam int CW = bcnt_width(NB);
  localparam logic [CW-1:0] LAST_CNT = CW'(NB - 1);

  logic [NBITS-1:0] r_word;
  logic [CW-1:0]    r_cnt;
  logic             r_valid;
  logic             w_accept;

  assign w_accept   = r_valid & i_tx_ready;
  assign o_last_acc = w_accept & (r_cnt == LAST_CNT);

  // Outputs come straight from registers, so ready never reaches valid/data combinationally.
  assign o_tx_valid = r_valid;
  assign o_tx_data  = r_word[NBITS-1 -: 8];

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_word  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_word  <= i_word;
      r_cnt   <= '0;
      r_valid <= 1'b1;
    end else if (w_accept) begin
      // After the last shift the word is all zeros, so idle data reads as 0.
      r_word  <= r_word << 8;
      r_cnt   <= r_cnt + CW'(1);
      r_valid <= ~o_last_acc;
    end
  end

endmodule

// File: rtl/debug_mem_dump.sv
`timescale 1ns/1ps
// Debug dumper: on start, reads data-memory words 0..CELDAS-1 and streams them out MSB byte first.
// Latency: READ the cycle after start is sampled, first byte valid one cycle later; 1+NBITS/8 cycles/word at full rate.
// Backpressure: i_tx_ready stalls the serializer; the address only advances after a word's last byte.
//
// Ports:
//   i_clk, i_reset                clock, async active-low reset
//   i_start                       start request, honoured only in IDLE
//   o_MemRead, o_MemDireccion     read strobe and word index to data memory
//   i_DatoLeido                   combinational read data, valid with o_MemRead
//   o_tx_data/o_tx_valid/i_tx_ready  byte stream to UART TX
//   o_busy                        high in READ and SEND
//   o_done                        one-cycle completion pulse
module debug_mem_dump
  import debug_mem_dump_pkg::*;
#(
  parameter int NBITS  = 32,
  parameter int CELDAS = 10
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  output logic             o_MemRead,
  output logic [NBITS-1:0] o_MemDireccion,
  input  logic [NBITS-1:0] i_DatoLeido,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_valid,
  input  logic             i_tx_ready,
  output logic             o_busy,
  output logic             o_done
);

  localparam int AW = (CELDAS > 1) ? $clog2(CELDAS) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(CELDAS - 1);

  logic [1:0]    r_state;
  logic [AW-1:0] r_addr;
  logic          w_load;
  logic          w_last_acc;

  // The memory read and the serializer load happen in the same READ cycle,
  // since the read data is combinational.
  assign w_load = (r_state == READ);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= READ;
            r_addr  <= '0;
          end
        end
        READ: r_state <= SEND;
        SEND: begin
          if (w_last_acc) begin
            // Address stops at the last word; it never wraps.
            if (r_addr == LAST_ADDR) begin
              r_state <= DONE;
            end else begin
              r_addr  <= r_addr + AW'(1);
              r_state <= READ;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_MemRead      = w_load;
  assign o_MemDireccion = NBITS'(r_addr);
  assign o_busy         = (r_state == READ) | (r_state == SEND);
  assign o_done         = (r_state == DONE);

  debug_mem_dump_word_serializer #(
    .NBITS (NBITS)
  ) u_ser (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_load),
    .i_word     (i_DatoLeido),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_last_acc (w_last_acc)
  );

endmodule
